// File: rtl/wb_bram32_ctrl.sv
// rtl/wb_bram32_ctrl.sv - Wishbone B3 slave driving port A of a 32-bit byte-writable block RAM
//
// Purpose:
//   Converts Wishbone classic single cycles and registered incrementing
//   bursts (CTI=010, linear or wrap4/8/16) into block RAM port A accesses.
//   The one-cycle BRAM read latency is hidden by prefetching, so a running
//   burst delivers one beat per clock. During master wait states the BRAM
//   clock enable is dropped so the prefetched word stays on bram_dout.
//
// Ports:
//   clk, rst_n       system clock (also BRAM port A clock), async active-low reset
//   wb_cyc_i         bus cycle
//   wb_stb_i         strobe
//   wb_we_i          1 = write
//   wb_sel_i[3:0]    byte selects
//   wb_adr_i         byte address, [addr_width+1:2] selects the word
//   wb_dat_i[31:0]   write data
//   wb_cti_i[2:0]    cycle type: 000 classic, 010 incrementing burst, 111 end
//   wb_bte_i[1:0]    burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//   wb_dat_o[31:0]   read data (straight from bram_dout)
//   wb_ack_o         acknowledge
//   bram_clken       BRAM clock enable (CE and OCE)
//   bram_addr        BRAM word address
//   bram_we[3:0]     BRAM byte write enables
//   bram_din[31:0]   BRAM write data (straight from wb_dat_i)
//   bram_dout[31:0]  BRAM read data, valid one enabled clock after the address

module wb_bram32_ctrl #(
  parameter int addr_width = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [addr_width+1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  bram_clken,
  output logic [addr_width-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RACK  = 2'd1,
    WACK  = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;     // next word to prefetch in a read burst
  logic [1:0]            bte_q, bte_d;     // burst type latched at burst start
  logic                  bwe_q, bwe_d;     // burst direction latched at burst start
  logic                  ready_q;          // low until the first clock after reset

  logic                  go;
  logic [addr_width-1:0] adr_word;
  logic                  unused_adr_lsb;

  assign adr_word       = wb_adr_i[addr_width+1:2];
  assign unused_adr_lsb = ^wb_adr_i[1:0];
  assign go             = wb_cyc_i & wb_stb_i & ready_q;

  assign wb_dat_o = bram_dout;
  assign bram_din = wb_dat_i;

  // Wrapping bursts only advance the low 2/3/4 bits; the rest of the address
  // stays inside the aligned wrap block.
  function automatic logic [addr_width-1:0] next_addr(input logic [addr_width-1:0] a,
                                                      input logic [1:0]            bte);
    logic [addr_width-1:0] n;
    n = a;
    case (bte)
      2'b00:   n      = a + ADDR_ONE;
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      default: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bte_d      = bte_q;
    bwe_d      = bwe_q;
    wb_ack_o   = 1'b0;
    bram_clken = 1'b0;
    bram_we    = 4'b0000;
    bram_addr  = adr_word;

    case (state_q)
      IDLE: begin
        // Reads are issued straight away so the data is ready for the ack cycle.
        bram_clken = go & ~wb_we_i;
        if (go) begin
          bwe_d = wb_we_i;
          bte_d = wb_bte_i;
          if (!wb_we_i) begin
            cnt_d = next_addr(adr_word, wb_bte_i);
          end
          if (wb_cti_i == 3'b010) begin
            state_d = BURST;
          end else begin
            state_d = wb_we_i ? WACK : RACK;
          end
        end
      end

      RACK: begin
        // clken stays low so bram_dout holds the word read in IDLE.
        wb_ack_o = wb_cyc_i;
        state_d  = IDLE;
      end

      WACK: begin
        wb_ack_o   = wb_cyc_i;
        bram_clken = wb_cyc_i;
        bram_we    = wb_sel_i & {4{wb_cyc_i}};
        state_d    = IDLE;
      end

      BURST: begin
        wb_ack_o   = go;
        bram_clken = go;
        if (bwe_q) begin
          bram_we = wb_sel_i & {4{go}};
        end else begin
          // Each acked beat returns the prefetched word and fetches the next.
          bram_addr = cnt_q;
          if (go) begin
            cnt_d = next_addr(cnt_q, bte_q);
          end
        end
        if (go && (wb_cti_i == 3'b111)) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!wb_cyc_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bte_q   <= 2'b00;
      bwe_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bte_q   <= bte_d;
      bwe_q   <= bwe_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_bram32_ctrl.sv
// tb/tb_wb_bram32_ctrl.sv - directed self-checking bench for wb_bram32_ctrl

module tb_wb_bram32_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [3:0]  wb_sel = 4'h0;
  logic [13:0] wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [2:0]  wb_cti = 3'b000;
  logic [1:0]  wb_bte = 2'b00;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        bram_clken;
  logic [11:0] bram_addr;
  logic [3:0]  bram_we;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] mem [0:4095];
  logic [31:0] exp_seq [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_bram32_ctrl #(.addr_width(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_cyc_i   (wb_cyc),
    .wb_stb_i   (wb_stb),
    .wb_we_i    (wb_we),
    .wb_sel_i   (wb_sel),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_dat_w),
    .wb_cti_i   (wb_cti),
    .wb_bte_i   (wb_bte),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .bram_clken (bram_clken),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout)
  );

  // Read-first block RAM model with a bench-side preload port.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bram_clken) begin
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
      end
      bram_dout <= mem[bram_addr];
    end
  end

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0;
    wb_cti = 3'b000; wb_bte = 2'b00;
  endtask

  task automatic test_reset();
    load(12'h004, 32'h12345678);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
    wb_adr = 14'h0010; wb_dat_w = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", wb_ack_o); end
      n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL rst_bram_we: got %h want 0", bram_we); end
      n_cmp++; if (bram_clken !== 1'b0) begin n_err++; $display("FAIL rst_clken: got %b want 0", bram_clken); end
      @(posedge clk); #1;
    end
    bus_idle();
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (mem[12'h004] !== 32'h12345678) begin n_err++; $display("FAIL rst_mem: got %h want 12345678", mem[12'h004]); end
  endtask

  task automatic test_classic_write();
    load(12'h004, 32'h0);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'b0101;
    wb_adr = 14'h0010; wb_dat_w = 32'hAABBCCDD; wb_cti = 3'b000;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL wr_ack_c0: got %b want 0", wb_ack_o); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL wr_we_c0: got %h want 0", bram_we); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL wr_ack_c1: got %b want 1", wb_ack_o); end
    n_cmp++; if (bram_we !== 4'b0101) begin n_err++; $display("FAIL wr_we_c1: got %h want 5", bram_we); end
    n_cmp++; if (bram_addr !== 12'h004) begin n_err++; $display("FAIL wr_addr_c1: got %h want 004", bram_addr); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL wr_ack_c2: got %b want 0", wb_ack_o); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL wr_we_c2: got %h want 0", bram_we); end
    n_cmp++; if (mem[12'h004] !== 32'h00BB00DD) begin n_err++; $display("FAIL wr_mem: got %h want 00BB00DD", mem[12'h004]); end
    @(posedge clk); #1;
  endtask

  task automatic test_classic_read();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 14'h0010; wb_cti = 3'b000;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_ack_c0: got %b want 0", wb_ack_o); end
    n_cmp++; if (bram_clken !== 1'b1) begin n_err++; $display("FAIL rd_clken_c0: got %b want 1", bram_clken); end
    n_cmp++; if (bram_addr !== 12'h004) begin n_err++; $display("FAIL rd_addr_c0: got %h want 004", bram_addr); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL rd_ack_c1: got %b want 1", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== 32'h00BB00DD) begin n_err++; $display("FAIL rd_dat: got %h want 00BB00DD", wb_dat_o); end
    n_cmp++; if (bram_clken !== 1'b0) begin n_err++; $display("FAIL rd_clken_c1: got %b want 0", bram_clken); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rd_ack_c2: got %b want 0", wb_ack_o); end
    @(posedge clk); #1;
  endtask

  // Drives one read burst and checks every beat against exp_seq; with
  // follow set, a classic read of the start word is issued right after to
  // show the burst really returned to IDLE.
  task automatic run_burst_read(input logic [11:0] start, input logic [1:0] bte,
                                input string tag, input bit follow);
    int nb;
    nb = exp_seq.size();
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = {start, 2'b00}; wb_cti = 3'b010; wb_bte = bte;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL %s_ack_first: got %b want 0", tag, wb_ack_o); end
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      wb_cti = (i == nb - 1) ? 3'b111 : 3'b010;
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL %s_ack_beat%0d: got %b want 1", tag, i, wb_ack_o); end
      n_cmp++; if (wb_dat_o !== exp_seq[i]) begin n_err++; $display("FAIL %s_dat_beat%0d: got %h want %h", tag, i, wb_dat_o, exp_seq[i]); end
      @(posedge clk); #1;
    end
    if (follow) begin
      wb_cti = 3'b000; wb_bte = 2'b00; wb_adr = {start, 2'b00};
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL %s_idle_ack0: got %b want 0", tag, wb_ack_o); end
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL %s_idle_ack1: got %b want 1", tag, wb_ack_o); end
      n_cmp++; if (wb_dat_o !== exp_seq[0]) begin n_err++; $display("FAIL %s_idle_dat: got %h want %h", tag, wb_dat_o, exp_seq[0]); end
      @(posedge clk); #1;
    end
    bus_idle();
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL %s_ack_end: got %b want 0", tag, wb_ack_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_linear_burst();
    exp_seq = '{32'd4, 32'd5, 32'd6, 32'd7};
    run_burst_read(12'h004, 2'b00, "lin", 1'b1);
  endtask

  task automatic test_wrap_bursts();
    exp_seq = '{32'd6, 32'd7, 32'd4, 32'd5};
    run_burst_read(12'h006, 2'b01, "wrap4", 1'b0);
    exp_seq = '{32'h0E, 32'h0F, 32'h08, 32'h09, 32'h0A, 32'h0B, 32'h0C, 32'h0D};
    run_burst_read(12'h00E, 2'b10, "wrap8", 1'b0);
  endtask

  task automatic test_wait_state();
    logic [31:0] want [4];
    want = '{32'd8, 32'd9, 32'd10, 32'd11};
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF;
    wb_adr = 14'h0020; wb_cti = 3'b010; wb_bte = 2'b00;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL ws_ack_first: got %b want 0", wb_ack_o); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wb_stb = 1'b0;
        for (int w = 0; w < 3; w++) begin
          @(negedge clk);
          n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL ws_ack_wait%0d: got %b want 0", w, wb_ack_o); end
          n_cmp++; if (bram_clken !== 1'b0) begin n_err++; $display("FAIL ws_clken_wait%0d: got %b want 0", w, bram_clken); end
          n_cmp++; if (wb_dat_o !== 32'd10) begin n_err++; $display("FAIL ws_hold_wait%0d: got %h want 0000000a", w, wb_dat_o); end
          @(posedge clk); #1;
        end
        wb_stb = 1'b1;
      end
      wb_cti = (i == 3) ? 3'b111 : 3'b010;
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL ws_ack_beat%0d: got %b want 1", i, wb_ack_o); end
      n_cmp++; if (wb_dat_o !== want[i]) begin n_err++; $display("FAIL ws_dat_beat%0d: got %h want %h", i, wb_dat_o, want[i]); end
      @(posedge clk); #1;
    end
    bus_idle();
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL ws_ack_end: got %b want 0", wb_ack_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_burst();
    logic [11:0] words [4];
    words = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 4; i++) load(words[i], 32'hCAFE0000 | 32'(i));
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
    wb_adr = {words[0], 2'b00}; wb_dat_w = 32'hA0000000; wb_cti = 3'b010; wb_bte = 2'b00;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL wb_ack_first: got %b want 0", wb_ack_o); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL wb_we_first: got %h want 0", bram_we); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      wb_adr = {words[i], 2'b00}; wb_dat_w = 32'hA0000000 | 32'(i);
      wb_cti = (i == 3) ? 3'b111 : 3'b010;
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL wb_ack_beat%0d: got %b want 1", i, wb_ack_o); end
      n_cmp++; if (bram_we !== 4'hF) begin n_err++; $display("FAIL wb_we_beat%0d: got %h want f", i, bram_we); end
      n_cmp++; if (bram_addr !== words[i]) begin n_err++; $display("FAIL wb_addr_beat%0d: got %h want %h", i, bram_addr, words[i]); end
      @(posedge clk); #1;
    end
    bus_idle();
    @(posedge clk); #1;
    n_cmp++; if (mem[12'hFFE] !== 32'hA0000000) begin n_err++; $display("FAIL wb_mem_ffe: got %h want a0000000", mem[12'hFFE]); end
    n_cmp++; if (mem[12'hFFF] !== 32'hA0000001) begin n_err++; $display("FAIL wb_mem_fff: got %h want a0000001", mem[12'hFFF]); end
    n_cmp++; if (mem[12'h000] !== 32'hA0000002) begin n_err++; $display("FAIL wb_mem_000: got %h want a0000002", mem[12'h000]); end
    n_cmp++; if (mem[12'h001] !== 32'hA0000003) begin n_err++; $display("FAIL wb_mem_001: got %h want a0000003", mem[12'h001]); end
  endtask

  task automatic test_write_abort();
    for (int i = 0; i < 4; i++) load(12'h010 + 12'(i), 32'h55000010 + 32'(i));
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
    wb_adr = 14'h0040; wb_dat_w = 32'hB0000000; wb_cti = 3'b010; wb_bte = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      wb_adr = 14'h0040 + 14'(4 * i); wb_dat_w = 32'hB0000000 | 32'(i);
      @(negedge clk);
      n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL ab_ack_beat%0d: got %b want 1", i, wb_ack_o); end
      @(posedge clk); #1;
    end
    // Cycle dropped while the strobe and next beat are still presented.
    wb_cyc = 1'b0; wb_adr = 14'h0048; wb_dat_w = 32'hB0000002;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL ab_ack_drop: got %b want 0", wb_ack_o); end
    n_cmp++; if (bram_we !== 4'h0) begin n_err++; $display("FAIL ab_we_drop: got %h want 0", bram_we); end
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_cti = 3'b000; wb_adr = 14'h0048;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL ab_rd_ack0: got %b want 0", wb_ack_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (wb_ack_o !== 1'b1) begin n_err++; $display("FAIL ab_rd_ack1: got %b want 1", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== 32'h55000012) begin n_err++; $display("FAIL ab_rd_dat: got %h want 55000012", wb_dat_o); end
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk); #1;
    n_cmp++; if (mem[12'h010] !== 32'hB0000000) begin n_err++; $display("FAIL ab_mem_010: got %h want b0000000", mem[12'h010]); end
    n_cmp++; if (mem[12'h011] !== 32'hB0000001) begin n_err++; $display("FAIL ab_mem_011: got %h want b0000001", mem[12'h011]); end
    n_cmp++; if (mem[12'h012] !== 32'h55000012) begin n_err++; $display("FAIL ab_mem_012: got %h want 55000012", mem[12'h012]); end
    n_cmp++; if (mem[12'h013] !== 32'h55000013) begin n_err++; $display("FAIL ab_mem_013: got %h want 55000013", mem[12'h013]); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_classic_write();
    test_classic_read();
    for (int n = 0; n < 32; n++) load(12'(n), 32'(n));
    test_linear_burst();
    test_wrap_bursts();
    test_wait_state();
    test_write_burst();
    test_write_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
